bp_trainer_param: RTL and testbench

//  Parametrised backpropagation update engine for an N_IN-N_HID-1 MLP (ReLU hidden layer, sigmoid output).

---
 rtl/bp_pkg.sv | 40 ++++
 rtl/bp_fx_mul.sv | 20 ++
 rtl/bp_trainer_param.sv | 212 +++++++++++++++++++++
 tb/tb_bp_trainer_param.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared state encoding and fixed-point helpers for the backprop update engine.
package bp_pkg;

  localparam int unsigned FX_W = 64;
  typedef logic signed [FX_W-1:0] fx_wide_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ERR   = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DOUT  = 3'd3;
  localparam logic [2:0] ST_HID   = 3'd4;
  localparam logic [2:0] ST_BOUT  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  // Fixed-point 1.0 and 0.5 for a given number of fractional bits.
  function automatic fx_wide_t fx_one(input int unsigned frac_w);
    return fx_wide_t'(1) <<< frac_w;
  endfunction

  function automatic fx_wide_t fx_half(input int unsigned frac_w);
    return (frac_w == 0) ? fx_wide_t'(0) : fx_one(frac_w - 1);
  endfunction

  // Clamp a wide value into a signed w-bit range.
  function automatic fx_wide_t sat(input fx_wide_t v, input int unsigned w);
    fx_wide_t hi;
    fx_wide_t lo;
    hi = fx_one(w - 1) - fx_wide_t'(1);
    lo = -fx_one(w - 1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Round-half-up and drop the fractional bits of a double-width product.
  function automatic fx_wide_t rnd(input fx_wide_t p, input int unsigned frac_w);
    return (p + fx_half(frac_w)) >>> frac_w;
  endfunction

endpackage

// File: rtl/bp_fx_mul.sv
// Signed fixed-point multiply with rounding and saturation back to DATA_W bits.
module bp_fx_mul
  import bp_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] p_c
);

  fx_wide_t prod;

  always_comb begin
    prod = fx_wide_t'(a) * fx_wide_t'(b);
    p_c  = DATA_W'(sat(rnd(prod, FRAC_W), DATA_W));
  end

endmodule

// File: rtl/bp_trainer_param.sv
// One-sample SGD update for an N_IN-N_HID-1 MLP, one hidden neuron per cycle.
// Optional delta clamping to +/-CLIP_MAX when BP_GRAD_CLIP_EN is defined.
module bp_trainer_param
  import bp_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FRAC_W   = 8,
  parameter int unsigned N_IN     = 2,
  parameter int unsigned N_HID    = 2,
  parameter int unsigned CLIP_MAX = 512
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [DATA_W-1:0]               target,
  input  logic [DATA_W-1:0]               y,
  input  logic [N_IN*DATA_W-1:0]          x,
  input  logic [N_HID*DATA_W-1:0]         h,
  input  logic [N_HID*N_IN*DATA_W-1:0]    w_hid_in,
  input  logic [N_HID*DATA_W-1:0]         b_hid_in,
  input  logic [N_HID*DATA_W-1:0]         w_out_in,
  input  logic [DATA_W-1:0]               b_out_in,
  input  logic [DATA_W-1:0]               lr,
  input  logic [DATA_W-1:0]               err_thresh,
  output logic [N_HID*N_IN*DATA_W-1:0]    w_hid_out,
  output logic [N_HID*DATA_W-1:0]         b_hid_out,
  output logic [N_HID*DATA_W-1:0]         w_out_out,
  output logic [DATA_W-1:0]               b_out_out,
  output logic [DATA_W-1:0]               sq_error,
  output logic                            busy,
  output logic                            upd_valid,
  output logic                            converged
);

  localparam int unsigned J_W = (N_HID > 1) ? $clog2(N_HID) : 1;

`ifdef BP_GRAD_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic [2:0] state, state_nxt;
  logic       conv_c;
  logic [J_W-1:0] j_q;

  // Snapshot of the request taken at the start edge.
  logic [DATA_W-1:0]            tgt_q, y_q, lr_q, thr_q, b_out_q;
  logic [N_IN*DATA_W-1:0]       x_q;
  logic [N_HID*DATA_W-1:0]      h_q, b_hid_q, w_out_q;
  logic [N_HID*N_IN*DATA_W-1:0] w_hid_q;

  logic signed [DATA_W-1:0] e_q, d_out_q, g_out_q;

  int unsigned              hofs_c, wofs_c;
  logic signed [DATA_W-1:0] hj_c, wj_c, e_c, one_my_c;
  logic signed [DATA_W-1:0] m0_a, m0_b, m0_p, m1_a, m1_b, m1_p, m2_b, m2_p;
  logic signed [DATA_W-1:0] dout_c, dj_c;
  logic signed [DATA_W-1:0] lane_p [N_IN];

  function automatic logic signed [DATA_W-1:0] add_sat(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    return DATA_W'(sat(fx_wide_t'(a) + fx_wide_t'(b), DATA_W));
  endfunction

  function automatic logic signed [DATA_W-1:0] clip(input logic signed [DATA_W-1:0] v);
    fx_wide_t lim;
    lim = fx_wide_t'(CLIP_MAX);
    if (!CLIP_EN) return v;
    if (fx_wide_t'(v) > lim) return DATA_W'(lim);
    if (fx_wide_t'(v) < -lim) return DATA_W'(-lim);
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    conv_c    = $signed(sq_error) < $signed(thr_q);
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ERR;
      ST_ERR:   state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = conv_c ? ST_DONE : ST_DOUT;
      ST_DOUT:  state_nxt = ST_HID;
      ST_HID:   if (j_q == J_W'(N_HID - 1)) state_nxt = ST_BOUT;
      ST_BOUT:  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // First multiplier: e*e in ERR, y*(1-y) in DOUT, d_out*w_out[j] in HID.
  always_comb begin
    hofs_c   = 32'(j_q) * DATA_W;
    wofs_c   = 32'(j_q) * N_IN * DATA_W;
    hj_c     = $signed(h_q[hofs_c +: DATA_W]);
    wj_c     = $signed(w_out_q[hofs_c +: DATA_W]);
    e_c      = DATA_W'(sat(fx_wide_t'($signed(tgt_q)) - fx_wide_t'($signed(y_q)), DATA_W));
    one_my_c = DATA_W'(sat(fx_one(FRAC_W) - fx_wide_t'($signed(y_q)), DATA_W));
    m0_a     = e_c;
    m0_b     = e_c;
    if (state == ST_DOUT) begin
      m0_a = $signed(y_q);
      m0_b = one_my_c;
    end else if (state == ST_HID) begin
      m0_a = d_out_q;
      m0_b = wj_c;
    end
  end

  // Second/third multipliers: d_out and g_out in DOUT; w_out step and g_j in HID.
  always_comb begin
    m1_a = g_out_q;
    m1_b = hj_c;
    if (state == ST_DOUT) begin
      m1_a = e_q;
      m1_b = m0_p;
    end
    dout_c = clip(m1_p);
    dj_c   = (hj_c > 0) ? clip(m0_p) : '0;
    m2_b   = (state == ST_DOUT) ? dout_c : dj_c;
  end

  bp_fx_mul #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul0 (.a(m0_a), .b(m0_b), .p_c(m0_p));
  bp_fx_mul #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul1 (.a(m1_a), .b(m1_b), .p_c(m1_p));
  bp_fx_mul #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul2 (.a($signed(lr_q)), .b(m2_b), .p_c(m2_p));

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    bp_fx_mul #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul (
      .a  (m2_p),
      .b  ($signed(x_q[i*DATA_W +: DATA_W])),
      .p_c(lane_p[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q     <= '0;
      y_q       <= '0;
      lr_q      <= '0;
      thr_q     <= '0;
      b_out_q   <= '0;
      x_q       <= '0;
      h_q       <= '0;
      b_hid_q   <= '0;
      w_out_q   <= '0;
      w_hid_q   <= '0;
      e_q       <= '0;
      d_out_q   <= '0;
      g_out_q   <= '0;
      j_q       <= '0;
      w_hid_out <= '0;
      b_hid_out <= '0;
      w_out_out <= '0;
      b_out_out <= '0;
      sq_error  <= '0;
      busy      <= 1'b0;
      upd_valid <= 1'b0;
      converged <= 1'b0;
    end else begin
      busy      <= (state_nxt != ST_IDLE);
      upd_valid <= (state_nxt == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            tgt_q   <= target;
            y_q     <= y;
            lr_q    <= lr;
            thr_q   <= err_thresh;
            b_out_q <= b_out_in;
            x_q     <= x;
            h_q     <= h;
            b_hid_q <= b_hid_in;
            w_out_q <= w_out_in;
            w_hid_q <= w_hid_in;
            j_q     <= '0;
          end
        end
        ST_ERR: begin
          e_q      <= e_c;
          sq_error <= m0_p;
        end
        ST_CHECK: begin
          converged <= conv_c;
          w_hid_out <= w_hid_q;
          b_hid_out <= b_hid_q;
          w_out_out <= w_out_q;
          b_out_out <= b_out_q;
        end
        ST_DOUT: begin
          d_out_q <= dout_c;
          g_out_q <= m2_p;
        end
        ST_HID: begin
          w_out_out[hofs_c +: DATA_W] <= add_sat($signed(w_out_out[hofs_c +: DATA_W]), m1_p);
          b_hid_out[hofs_c +: DATA_W] <= add_sat($signed(b_hid_out[hofs_c +: DATA_W]), m2_p);
          for (int i = 0; i < N_IN; i++) begin
            w_hid_out[wofs_c + i*DATA_W +: DATA_W] <=
              add_sat($signed(w_hid_out[wofs_c + i*DATA_W +: DATA_W]), lane_p[i]);
          end
          j_q <= j_q + J_W'(1);
        end
        ST_BOUT: b_out_out <= add_sat($signed(b_out_out), g_out_q);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_trainer_param.sv
// Directed bench for bp_trainer_param (Q8.8, two inputs, two hidden neurons).
module tb_bp_trainer_param;

  localparam int DW = 16;
  localparam int NI = 2;
  localparam int NH = 2;
  localparam int CLIP = 16;

  logic                clk = 1'b0;
  logic                rst, start;
  logic [DW-1:0]       target, y, lr, err_thresh, b_out_in;
  logic [NI*DW-1:0]    x;
  logic [NH*DW-1:0]    h, b_hid_in, w_out_in;
  logic [NH*NI*DW-1:0] w_hid_in;
  logic [NH*NI*DW-1:0] w_hid_out;
  logic [NH*DW-1:0]    b_hid_out, w_out_out;
  logic [DW-1:0]       b_out_out, sq_error;
  logic                busy, upd_valid, converged;

  bp_trainer_param #(.DATA_W(DW), .FRAC_W(8), .N_IN(NI), .N_HID(NH), .CLIP_MAX(CLIP)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .y(y), .x(x), .h(h),
    .w_hid_in(w_hid_in), .b_hid_in(b_hid_in), .w_out_in(w_out_in), .b_out_in(b_out_in),
    .lr(lr), .err_thresh(err_thresh), .w_hid_out(w_hid_out), .b_hid_out(b_hid_out),
    .w_out_out(w_out_out), .b_out_out(b_out_out), .sq_error(sq_error), .busy(busy),
    .upd_valid(upd_valid), .converged(converged)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Stimulus and expected results as plain signed integers.
  int s_tgt, s_y, s_lr, s_thr, s_bo;
  int s_x [NI];
  int s_h [NH];
  int s_bh [NH];
  int s_wo [NH];
  int s_wh [NH][NI];
  int e_sq, e_conv, e_bo;
  int e_bh [NH];
  int e_wo [NH];
  int e_wh [NH][NI];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint rnd(input longint p);
    return sat16((p + 128) >>> 8);
  endfunction

  function automatic longint clip_d(input longint v);
`ifdef BP_GRAD_CLIP_EN
    if (v > CLIP) return CLIP;
    if (v < -CLIP) return -CLIP;
`endif
    return v;
  endfunction

  task automatic model();
    longint e, dout, gout, dj, gj;
    e      = sat16(longint'(s_tgt) - longint'(s_y));
    e_sq   = int'(rnd(e * e));
    e_conv = (e_sq < s_thr) ? 1 : 0;
    e_bo   = s_bo;
    e_bh   = s_bh;
    e_wo   = s_wo;
    e_wh   = s_wh;
    if (e_conv == 0) begin
      dout = clip_d(rnd(e * rnd(longint'(s_y) * sat16(256 - longint'(s_y)))));
      gout = rnd(longint'(s_lr) * dout);
      for (int j = 0; j < NH; j++) begin
        dj = (s_h[j] > 0) ? clip_d(rnd(dout * s_wo[j])) : 0;
        e_wo[j] = int'(sat16(longint'(s_wo[j]) + rnd(gout * s_h[j])));
        gj = rnd(longint'(s_lr) * dj);
        for (int i = 0; i < NI; i++)
          e_wh[j][i] = int'(sat16(longint'(s_wh[j][i]) + rnd(gj * s_x[i])));
        e_bh[j] = int'(sat16(longint'(s_bh[j]) + gj));
      end
      e_bo = int'(sat16(longint'(s_bo) + gout));
    end
  endtask

  task automatic drive();
    target = 16'(s_tgt); y = 16'(s_y); lr = 16'(s_lr); err_thresh = 16'(s_thr);
    b_out_in = 16'(s_bo);
    for (int i = 0; i < NI; i++) x[i*DW +: DW] = 16'(s_x[i]);
    for (int j = 0; j < NH; j++) begin
      h[j*DW +: DW]        = 16'(s_h[j]);
      b_hid_in[j*DW +: DW] = 16'(s_bh[j]);
      w_out_in[j*DW +: DW] = 16'(s_wo[j]);
      for (int i = 0; i < NI; i++) w_hid_in[(j*NI+i)*DW +: DW] = 16'(s_wh[j][i]);
    end
  endtask

  task automatic scramble();
    target = 16'($urandom); y = 16'($urandom); lr = 16'($urandom);
    err_thresh = 16'($urandom); b_out_in = 16'($urandom);
    x = $urandom; h = $urandom; b_hid_in = $urandom; w_out_in = $urandom;
    w_hid_in = {$urandom, $urandom};
  endtask

  task automatic set_base();
    s_tgt = 256; s_y = 128; s_lr = 256; s_thr = 16; s_bo = 256;
    s_x[0] = 256; s_x[1] = 0; s_h[0] = 256; s_h[1] = 0;
    for (int j = 0; j < NH; j++) begin
      s_bh[j] = 256; s_wo[j] = 256;
      for (int i = 0; i < NI; i++) s_wh[j][i] = 256;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wh"}, {w_hid_out[31:16] | w_hid_out[15:0] | w_hid_out[63:48] | w_hid_out[47:32]}, 16'h0);
    chk({tag, "_bh"}, b_hid_out[15:0] | b_hid_out[31:16], 16'h0);
    chk({tag, "_wo"}, w_out_out[15:0] | w_out_out[31:16], 16'h0);
    chk({tag, "_bo"}, b_out_out, 16'h0);
    chk({tag, "_sq"}, sq_error, 16'h0);
    chk({tag, "_flags"}, {13'b0, busy, upd_valid, converged}, 16'h0);
  endtask

  // Apply the current stimulus and track upd_valid/busy timing against exp_edge.
  task automatic run(input int exp_edge, input bit hold);
    int k;
    @(negedge clk);
    chk_en = 1'b0;
    #1;
    model();
    drive();
    start = 1'b1;
    for (k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        if (!hold) start = 1'b0;
        scramble();
        chk("busy_run", 16'(busy), 16'h1);
      end
      if (upd_valid) break;
    end
    chk("upd_edge", 16'(k), 16'(exp_edge));
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("upd_fall", 16'(upd_valid), 16'h0);
    chk("busy_end", 16'(busy), 16'h0);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scoreboard: once a run has completed, outputs must equal the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sq_error", sq_error, 16'(e_sq));
      chk("converged", 16'(converged), 16'(e_conv));
      chk("b_out", b_out_out, 16'(e_bo));
      for (int j = 0; j < NH; j++) begin
        chk($sformatf("w_out[%0d]", j), w_out_out[j*DW +: DW], 16'(e_wo[j]));
        chk($sformatf("b_hid[%0d]", j), b_hid_out[j*DW +: DW], 16'(e_bh[j]));
        for (int i = 0; i < NI; i++)
          chk($sformatf("w_hid[%0d][%0d]", j, i), w_hid_out[(j*NI+i)*DW +: DW], 16'(e_wh[j][i]));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    set_base();
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Converged: outputs are a copy of the inputs.
    set_base();
    s_tgt = 128; s_y = 128;
    s_wo[0] = 'h0123; s_wo[1] = -'h0045; s_bo = 'h0077; s_bh[1] = -'h0200; s_wh[1][0] = 'h0333;
    run(2, 1'b0);
    chk("t1_sq", sq_error, 16'h0000);
    chk("t1_conv", 16'(converged), 16'h1);
    chk("t1_wo1", w_out_out[31:16], 16'hFFBB);

    // Single step.
    set_base();
    run(6, 1'b0);
    chk("t2_sq", sq_error, 16'h0040);
    chk("t2_conv", 16'(converged), 16'h0);
`ifdef BP_GRAD_CLIP_EN
    chk("t6_wo0", w_out_out[15:0], 16'h0110);
`else
    chk("t2_wo0", w_out_out[15:0], 16'h0120);
    chk("t2_wo1", w_out_out[31:16], 16'h0100);
    chk("t2_bo", b_out_out, 16'h0120);
    chk("t2_wh00", w_hid_out[15:0], 16'h0120);
    chk("t2_wh01", w_hid_out[31:16], 16'h0100);
    chk("t2_bh0", b_hid_out[15:0], 16'h0120);
    chk("t2_bh1", b_hid_out[31:16], 16'h0100);
`endif

    // Saturating accumulate must not wrap.
    set_base();
    s_wo[0] = 'h7FF0;
    run(6, 1'b0);
    chk("t3_wo0", w_out_out[15:0], 16'h7FFF);

    // Negative error, gated neuron, start held high for the whole run.
    set_base();
    s_tgt = 0; s_y = 'h00C0; s_h[0] = 'h0080; s_h[1] = -'h0040; s_x[1] = -'h0180;
    s_wo[1] = 'h0300; s_lr = 'h0200;
    run(6, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("no_extra_upd", 16'(upd_valid), 16'h0);
      chk("idle_busy", 16'(busy), 16'h0);
    end

    // Reset while processing hidden neurons.
    @(negedge clk);
    chk_en = 1'b0;
    #1;
    set_base();
    drive();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 16'(busy), 16'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;

    // Fresh run after reset, mixed signs.
    s_tgt = 'h0200; s_y = 'h0040; s_lr = 'h0080; s_thr = 'h0010;
    s_x[0] = 'h0180; s_x[1] = -'h0100; s_h[0] = 'h0100; s_h[1] = 'h0200;
    s_wo[0] = -'h0080; s_wo[1] = 'h0140; s_bo = -'h0020;
    s_bh[0] = 'h0010; s_bh[1] = -'h0030;
    s_wh[0][0] = 'h0050; s_wh[0][1] = -'h0060; s_wh[1][0] = 'h0070; s_wh[1][1] = 'h0000;
    run(6, 1'b0);

    // Error saturates; threshold at max is not strictly exceeded.
    set_base();
    s_tgt = 'h7F00; s_y = -'h7F00; s_thr = 'h7FFF;
    run(6, 1'b0);
    chk("t7_sq", sq_error, 16'h7FFF);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
